// File: rtl/count_mon_pkg.sv
// count_mon_pkg: state encoding and default widths shared by the count sequence monitor.
package count_mon_pkg;
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_TRACK = 2'd1,
        ST_FAULT = 2'd2
    } state_t;
    localparam int DEF_WIDTH  = 4;
    localparam int DEF_WRAP_W = 8;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: up counter that sticks at its maximum value; reset > clr > inc.
module sat_counter #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);
    always_ff @(posedge clk) begin
        if (reset || clr) q <= '0;
        else if (inc && !(&q)) q <= q + 1'b1;
    end
endmodule

// File: rtl/count_seq_monitor.sv
// count_seq_monitor: checks that a sampled counter advances by exactly one each valid cycle,
// latching the first violation and counting clean wrap-arounds.
module count_seq_monitor
    import count_mon_pkg::*;
#(
    parameter int WIDTH  = DEF_WIDTH,
    parameter int WRAP_W = DEF_WRAP_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              count_valid,
    input  logic [WIDTH-1:0]  count_in,
    input  logic              clear,
    output logic              wrap_pulse,
    output logic [WRAP_W-1:0] wrap_count,
    output logic              err,
    output logic [WIDTH-1:0]  err_expected,
    output logic [WIDTH-1:0]  err_actual,
    output logic [1:0]        state
);
    state_t           r_state, w_next;
    logic [WIDTH-1:0] r_prev, w_expected;
    logic             r_wrap_pulse, r_err, w_load, w_wrap, w_fault;
    logic [WIDTH-1:0] r_err_exp, r_err_act;
    always_comb begin
        w_next     = ST_IDLE;
        w_load     = 1'b0;
        w_wrap     = 1'b0;
        w_fault    = 1'b0;
        w_expected = r_prev + 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_next = count_valid ? ST_TRACK : ST_IDLE;
                w_load = count_valid;
            end
            ST_TRACK: begin
                if (count_valid && count_in == w_expected) begin
                    w_next = ST_TRACK;
                    w_load = 1'b1;
                    w_wrap = &r_prev;
                end else if (count_valid) begin
                    w_next  = ST_FAULT;
                    w_fault = 1'b1;
                end
            end
            ST_FAULT: w_next = ST_FAULT;
            default:  w_next = ST_IDLE;
        endcase
    end
    // prev survives clear; IDLE reloads it on the next valid sample anyway
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_prev       <= '0;
            r_wrap_pulse <= 1'b0;
            r_err        <= 1'b0;
            r_err_exp    <= '0;
            r_err_act    <= '0;
        end else if (clear) begin
            r_state      <= ST_IDLE;
            r_wrap_pulse <= 1'b0;
            r_err        <= 1'b0;
            r_err_exp    <= '0;
            r_err_act    <= '0;
        end else begin
            r_state      <= w_next;
            r_wrap_pulse <= w_wrap;
            if (w_load) r_prev <= count_in;
            if (w_fault) begin
                r_err     <= 1'b1;
                r_err_exp <= w_expected;
                r_err_act <= count_in;
            end
        end
    end
    sat_counter #(.W(WRAP_W)) u_wraps (
        .clk   (clk),
        .reset (reset),
        .clr   (clear),
        .inc   (w_wrap),
        .q     (wrap_count)
    );
    assign wrap_pulse   = r_wrap_pulse;
    assign err          = r_err;
    assign err_expected = r_err_exp;
    assign err_actual   = r_err_act;
    assign state        = r_state;
endmodule

// File: tb/tb_count_seq_monitor.sv
// tb_count_seq_monitor: directed vectors with a scoreboard; a wide and a 2-bit wrap counter
// instance share the same stimulus.
module tb_count_seq_monitor;
    typedef struct {
        logic       wp;
        logic [7:0] wc;
        logic [1:0] wc2;
        logic       er;
        logic [3:0] ee;
        logic [3:0] ea;
        logic [1:0] st;
    } exp_t;
    logic clk = 0, reset = 1, count_valid = 0, clear = 0;
    logic [3:0] count_in = 0;
    logic       wp, er, wp2, er2;
    logic [7:0] wc;
    logic [1:0] wc2, st, st2;
    logic [3:0] ee, ea, ee2, ea2;
    exp_t       q[$];
    int         checks = 0, errors = 0;
    always #5 clk = ~clk;
    count_seq_monitor dut (
        .clk(clk), .reset(reset), .count_valid(count_valid), .count_in(count_in), .clear(clear),
        .wrap_pulse(wp), .wrap_count(wc), .err(er), .err_expected(ee), .err_actual(ea), .state(st)
    );
    count_seq_monitor #(.WIDTH(4), .WRAP_W(2)) dut_s (
        .clk(clk), .reset(reset), .count_valid(count_valid), .count_in(count_in), .clear(clear),
        .wrap_pulse(wp2), .wrap_count(wc2), .err(er2), .err_expected(ee2), .err_actual(ea2), .state(st2)
    );
    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask
    always begin
        @(posedge clk);
        #1;
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            chk("state", int'(st), int'(e.st));
            chk("err", int'(er), int'(e.er));
            chk("err_expected", int'(ee), int'(e.ee));
            chk("err_actual", int'(ea), int'(e.ea));
            chk("wrap_pulse", int'(wp), int'(e.wp));
            chk("wrap_count", int'(wc), int'(e.wc));
            chk("sat_wrap_pulse", int'(wp2), int'(e.wp));
            chk("sat_wrap_count", int'(wc2), int'(e.wc2));
            chk("sat_state", int'(st2), int'(e.st));
        end
    end
    task automatic step(input logic r, input logic c, input logic v, input logic [3:0] cin,
                        input logic e_wp, input logic [7:0] e_wc, input logic e_er,
                        input logic [3:0] e_ee, input logic [3:0] e_ea, input logic [1:0] e_st);
        exp_t e;
        reset = r;
        clear = c;
        count_valid = v;
        count_in = cin;
        e.wp = e_wp;
        e.wc = e_wc;
        e.wc2 = (e_wc > 8'd3) ? 2'd3 : e_wc[1:0];
        e.er = e_er;
        e.ee = e_ee;
        e.ea = e_ea;
        e.st = e_st;
        q.push_back(e);
        @(posedge clk);
        #2;
    endtask
    initial begin
        @(posedge clk);
        #2;
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 18; i++) step(0, 0, 1, 4'(i), i == 16, (i >= 16) ? 8'd1 : 8'd0, 0, 0, 0, 1);
        for (int i = 2; i < 10; i++) step(0, 0, 1, 4'(i), 0, 1, 0, 0, 0, 1);
        repeat (2) step(0, 0, 0, 9, 0, 1, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i), 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 3, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 4, 0, 1, 0, 0, 0, 1);
        step(0, 0, 1, 6, 0, 1, 1, 5, 6, 2);
        step(0, 0, 1, 7, 0, 1, 1, 5, 6, 2);
        step(0, 0, 1, 9, 0, 1, 1, 5, 6, 2);
        step(0, 0, 0, 0, 0, 1, 1, 5, 6, 2);
        step(0, 1, 1, 7, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i), 0, 0, 0, 0, 0, 1);
        step(0, 1, 1, 5, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 4'(i), 0, 0, 0, 0, 0, 1);
        for (int i = 3; i < 8; i++) step(0, 0, 1, 4'(i), 0, 0, 0, 0, 0, 1);
        step(0, 0, 1, 7, 0, 0, 1, 8, 7, 2);
        step(1, 0, 1, 8, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i <= 80; i++)
            step(0, 0, 1, 4'(i % 16), i > 0 && i % 16 == 0, 8'(i / 16), 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 5, 0, 0, 0, 0);
        repeat (4) @(posedge clk);
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain actual=%0d required=0 pending entries", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/count_seq_monitor.md
# count_seq_monitor

Downstream checker for the 4-bit free-running up counter. It samples the counter value every clock and verifies that each sample is exactly the previous sample plus one, modulo 2^WIDTH. It flags the first sequence violation with a sticky error and captures the offending values, and it counts clean wrap-arounds (max→0). It sits directly on the counter's output bus and uses the counter's enable/reset line as its `count_valid`.

## Interface
- `WIDTH`, default 4: width of the monitored count.
- `WRAP_W`, default 8: width of the wrap-event counter.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high; clears all state.
- `count_valid` in 1: high while the upstream counter is running (its reset released).
- `count_in` in WIDTH: current upstream counter value.
- `clear` in 1: synchronous soft clear of error and statistics.
- `wrap_pulse` out 1: one-cycle pulse per clean max→0 transition.
- `wrap_count` out WRAP_W: number of clean wraps, saturating.
- `err` out 1: sticky sequence-violation flag.
- `err_expected` out WIDTH: expected value at the first violation.
- `err_actual` out WIDTH: sampled value at the first violation.
- `state` out 2: FSM state, for debug.

## Operation
- **FSM states:** IDLE=0, TRACK=1, FAULT=2. Encoding 3 is illegal and recovers to IDLE on the next edge.
- **Reset:** `state`=IDLE, internal `prev`=0, `wrap_pulse`=0, `wrap_count`=0, `err`=0, `err_expected`=0, `err_actual`=0.
- **Priority at each edge:** `reset` > `clear` > normal FSM.
- **`clear`:** go to IDLE; zero `err`, `err_expected`, `err_actual`, `wrap_count`, `wrap_pulse`.
- **IDLE:**
  - `count_valid`=1: `prev`←`count_in`, go to TRACK. No check on this first sample.
  - Otherwise stay in IDLE.
- **TRACK:**
  - `count_valid`=0: go to IDLE. Upstream counter restart is not an error.
  - Otherwise compute `expected` = (`prev`+1) mod 2^WIDTH, truncated to WIDTH bits.
  - `count_in`==`expected`: `prev`←`count_in`. If `prev`==2^WIDTH−1, assert `wrap_pulse` and increment `wrap_count` (saturating).
  - `count_in`≠`expected` (including a repeated value): `err`←1, `err_expected`←`expected`, `err_actual`←`count_in`, go to FAULT.
- **FAULT:**
  - Outputs hold; later mismatches do not overwrite the captured values.
  - `count_valid` is ignored.
  - Exit only via `clear` or `reset`.
- **Saturation:** `wrap_count` stops at 2^WRAP_W−1 and `wrap_pulse` still fires.

## Timing
- All outputs are registered. A sample taken at edge k produces `err`/`wrap_pulse` visible after edge k, i.e. 1-cycle latency.
- `wrap_pulse` is high for exactly one cycle per wrap. Back-to-back wraps are impossible for WIDTH≥1, since wraps are at least 2^WIDTH cycles apart.
- `count_valid` rising: the first check happens on the second valid sample.
- `count_valid` falling mid-TRACK: IDLE on that edge; no flag and no wrap counted.
- `clear` on the same edge as a mismatch: `clear` wins and `err` stays 0.
- `reset` mid-FAULT: everything returns to reset values on that edge.

## Structure
- Shared package `count_mon_pkg`: the state encoding constants (IDLE/TRACK/FAULT), default WIDTH=4, default WRAP_W=8.
- One sub-module, `sat_counter` (params W; ports `clk`, `reset`, `clr`, `inc`, `q`), implements the saturating `wrap_count` and is reusable elsewhere.
- The FSM, `prev` register and error capture live in the top module.

## Test plan
- **Reset then run:** `reset`=1 for 2 cycles, then `count_valid`=1 with `count_in` 0,1,…,15,0,1 → `err`=0, one `wrap_pulse` on the 15→0 edge, `wrap_count`=1.
- **Injected skip:** sequence 3,4,6 → after the edge that samples 6: `err`=1, `err_expected`=5, `err_actual`=6, `state`=FAULT. Subsequent values 7,9 leave the captured values unchanged.
- **Upstream restart:** running at 9, drop `count_valid` for 2 cycles, resume at 0,1,2 → `err`=0, no `wrap_pulse`, `state` goes TRACK→IDLE→TRACK.
- **Clear vs. mismatch:** pulse `clear` on the same edge as a bad sample (5 after 2) → `err`=0, `state`=IDLE. The next valid run of 0,1,2 is accepted cleanly.
- **Saturation:** WRAP_W=2, run 5 full wraps → `wrap_count` = 1,2,3,3,3, and `wrap_pulse` fires all 5 times.
- **Repeated value:** 7,7 → `err`=1, `err_expected`=8, `err_actual`=7.
